m68k_bus_decoder: RTL

Parametrised, registered successor to the combinational 68000 chip-select map. It decodes the 68000 address into up to `NUM_REGIONS` one-hot chip selects from a compile-time region table. Each region can be qualified by read or write direction and carries its own wait-state count. The block sits between the 68000 core and the board peripherals, and it generates `dtack_n`, plus `berr_n` when bus-error support is compiled in, so that slow SDRAM-backed regions and fast BRAM regions can share one bus.

---
 rtl/m68k_bus_decoder_if.sv | 27 ++
 rtl/m68k_bus_decoder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/m68k_bus_decoder_if.sv
// 68000 bus bundle between the CPU side (master) and the chip-select decoder (slave).
interface m68k_bus_decoder_if #(
    parameter int NUM_REGIONS = 8,
    parameter int ADDR_W      = 24
);
    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    logic [ADDR_W-1:0]      m68k_a;
    logic                   m68k_as_n;
    logic                   m68k_rw;
    logic [NUM_REGIONS-1:0] cs;
    logic [IDX_W-1:0]       hit_idx;
    logic                   miss;
    logic                   busy;
    logic                   dtack_n;
    logic                   berr_n;

    modport master (
        output m68k_a, m68k_as_n, m68k_rw,
        input  cs, hit_idx, miss, busy, dtack_n, berr_n
    );

    modport slave (
        input  m68k_a, m68k_as_n, m68k_rw,
        output cs, hit_idx, miss, busy, dtack_n, berr_n
    );
endinterface

// File: rtl/m68k_bus_decoder.sv
// Registered 68000 chip-select decoder with per-region direction qualification and wait states.
// Optional feature macro: DECODER_BERR_EN (bus-error timeout on unmapped accesses; otherwise open-bus DTACK).
module m68k_bus_decoder #(
    parameter int                            NUM_REGIONS  = 8,
    parameter int                            ADDR_W       = 24,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_START = '0,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_END   = '0,
    parameter logic [2*NUM_REGIONS-1:0]      REGION_RW    = '0,
    parameter logic [4*NUM_REGIONS-1:0]      REGION_WAIT  = '0,
    parameter int                            BERR_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    m68k_bus_decoder_if.slave  bus
);
    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    if (NUM_REGIONS < 1 || NUM_REGIONS > 32) begin : g_bad_regions
        $error("m68k_bus_decoder: NUM_REGIONS must be 1..32");
    end
    if (BERR_TIMEOUT < 2 || BERR_TIMEOUT > 255) begin : g_bad_timeout
        $error("m68k_bus_decoder: BERR_TIMEOUT must be 2..255");
    end

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WAIT, S_ACK, S_MISS} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   rw_q, rw_d;
    logic [NUM_REGIONS-1:0] cs_q, cs_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   miss_q, miss_d;
    logic                   busy_q, busy_d;
    logic                   dtack_q, dtack_d;
    logic [3:0]             wcnt_q, wcnt_d;
`ifdef DECODER_BERR_EN
    localparam logic [7:0]  TMO_LAST = 8'(BERR_TIMEOUT - 1);
    logic                   berr_q, berr_d;
    logic [7:0]             tmo_q, tmo_d;
`endif

    // Range test uses a 1-bit extension so that a region starting at 0 or
    // ending at all-ones never degenerates into a constant comparison.
    logic [NUM_REGIONS-1:0] match;
    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
        localparam logic [ADDR_W-1:0] LO  = REGION_START[g*ADDR_W +: ADDR_W];
        localparam logic [ADDR_W-1:0] HI  = REGION_END[g*ADDR_W +: ADDR_W];
        localparam logic [1:0]        DIR = REGION_RW[2*g +: 2];
        assign match[g] = ({addr_q, 1'b1} > {LO, 1'b0})
                       && ({addr_q, 1'b0} < {HI, 1'b1})
                       && (DIR != 2'b11)
                       && (DIR != 2'b01 || rw_q)
                       && (DIR != 2'b10 || !rw_q);
    end

    // Lowest set bit wins, which keeps cs one-hot when regions overlap.
    logic [NUM_REGIONS-1:0] sel;
    logic [IDX_W-1:0]       hit_i;
    logic [3:0]             hit_wait;
    assign sel = match & (~match + NUM_REGIONS'(1));

    always_comb begin
        hit_i = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (sel[i]) hit_i = IDX_W'(i);
        end
    end
    assign hit_wait = REGION_WAIT[hit_i*4 +: 4];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        cs_d    = cs_q;
        idx_d   = idx_q;
        miss_d  = miss_q;
        busy_d  = busy_q;
        dtack_d = dtack_q;
        wcnt_d  = wcnt_q;
`ifdef DECODER_BERR_EN
        berr_d  = berr_q;
        tmo_d   = tmo_q;
`endif
        if (state_q != S_IDLE && bus.m68k_as_n) begin
            state_d = S_IDLE;
            cs_d    = '0;
            idx_d   = '0;
            miss_d  = 1'b0;
            busy_d  = 1'b0;
            dtack_d = 1'b1;
            wcnt_d  = '0;
`ifdef DECODER_BERR_EN
            berr_d  = 1'b1;
            tmo_d   = '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!bus.m68k_as_n) begin
                        addr_d  = bus.m68k_a;
                        rw_d    = bus.m68k_rw;
                        busy_d  = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (|sel) begin
                        cs_d    = sel;
                        idx_d   = hit_i;
                        wcnt_d  = hit_wait;
                        state_d = (hit_wait != 4'd0) ? S_WAIT : S_ACK;
                    end else begin
                        miss_d  = 1'b1;
                        wcnt_d  = '0;
`ifdef DECODER_BERR_EN
                        tmo_d   = '0;
`endif
                        state_d = S_MISS;
                    end
                end
                S_WAIT: begin
                    wcnt_d = wcnt_q - 4'd1;
                    if (wcnt_q == 4'd1) state_d = S_ACK;
                end
                S_ACK: dtack_d = 1'b0;
                S_MISS: begin
`ifdef DECODER_BERR_EN
                    if (tmo_q != 8'hff) tmo_d = tmo_q + 8'd1;
                    if (tmo_q >= TMO_LAST) berr_d = 1'b0;
`else
                    dtack_d = 1'b0;
`endif
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rw_q    <= 1'b1;
            cs_q    <= '0;
            idx_q   <= '0;
            miss_q  <= 1'b0;
            busy_q  <= 1'b0;
            dtack_q <= 1'b1;
            wcnt_q  <= '0;
`ifdef DECODER_BERR_EN
            berr_q  <= 1'b1;
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            cs_q    <= cs_d;
            idx_q   <= idx_d;
            miss_q  <= miss_d;
            busy_q  <= busy_d;
            dtack_q <= dtack_d;
            wcnt_q  <= wcnt_d;
`ifdef DECODER_BERR_EN
            berr_q  <= berr_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign bus.cs      = cs_q;
    assign bus.hit_idx = idx_q;
    assign bus.miss    = miss_q;
    assign bus.busy    = busy_q;
    assign bus.dtack_n = dtack_q;
`ifdef DECODER_BERR_EN
    assign bus.berr_n  = berr_q;
`else
    assign bus.berr_n  = 1'b1;
`endif
endmodule
